// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic ops, bit-serial shifts,
// and valid/ready handshakes on both the issue and writeback sides.
module alu_exec_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_illegal,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shtype_t;
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
    OP_XOR  = 4'd4, OP_SLT = 4'd5, OP_SLTU = 4'd6, OP_SLL = 4'd7,
    OP_SRL  = 4'd8, OP_SRA = 4'd9
  } op_t;

  state_t            state_q, state_d;
  shtype_t           shty_q, shty_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              ill_q, ill_d;
  logic [XLEN-1:0]   sh_q, sh_d;
  logic [SHW-1:0]    cnt_q, cnt_d;

  logic [SHW-1:0]    shamt;
  logic              accept;
  logic [XLEN-1:0]   b_inv;
  logic [XLEN:0]     sub_full;
  logic              sub_ovf;
  logic              slt_bit;
  logic              sltu_bit;
  logic [XLEN-1:0]   sh_next;

  assign shamt  = in_b[SHW-1:0];
  assign accept = in_valid && (state_q == S_IDLE);

  // Subtract/compare path: a + ~b + 1 with carry-out kept for SLTU
  always_comb begin
    b_inv    = ~in_b;
    sub_full = {1'b0, in_a} + {1'b0, b_inv} + (XLEN+1)'(1);
    sub_ovf  = (in_a[XLEN-1] ^ in_b[XLEN-1]) & (sub_full[XLEN-1] ^ in_a[XLEN-1]);
    slt_bit  = sub_full[XLEN-1] ^ sub_ovf;
    sltu_bit = ~sub_full[XLEN];
  end

  // One-bit shift step of the serial shift register
  always_comb begin
    sh_next = sh_q;
    case (shty_q)
      SH_SLL:  sh_next = {sh_q[XLEN-2:0], 1'b0};
      SH_SRL:  sh_next = {1'b0, sh_q[XLEN-1:1]};
      SH_SRA:  sh_next = {sh_q[XLEN-1], sh_q[XLEN-1:1]};
      default: sh_next = sh_q;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if ((in_op == OP_SLL || in_op == OP_SRL || in_op == OP_SRA) && shamt != '0)
            state_d = S_SHIFT;
          else
            state_d = S_DONE;
        end
      end
      S_SHIFT: if (cnt_q == SHW'(1)) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers: result, illegal flag, shift register and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      ill_q  <= 1'b0;
      sh_q   <= '0;
      cnt_q  <= '0;
      shty_q <= SH_SLL;
    end else begin
      res_q  <= res_d;
      ill_q  <= ill_d;
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      shty_q <= shty_d;
    end
  end

  // Datapath next values: capture on accept, step while shifting
  always_comb begin
    res_d  = res_q;
    ill_d  = ill_q;
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    shty_d = shty_q;
    if (accept) begin
      ill_d = 1'b0;
      case (in_op)
        OP_ADD:  res_d = in_a + in_b;
        OP_SUB:  res_d = sub_full[XLEN-1:0];
        OP_AND:  res_d = in_a & in_b;
        OP_OR:   res_d = in_a | in_b;
        OP_XOR:  res_d = in_a ^ in_b;
        OP_SLT:  res_d = {{(XLEN-1){1'b0}}, slt_bit};
        OP_SLTU: res_d = {{(XLEN-1){1'b0}}, sltu_bit};
        OP_SLL, OP_SRL, OP_SRA: begin
          // Zero shift completes immediately; otherwise load the serial shifter
          if (shamt == '0) begin
            res_d = in_a;
          end else begin
            sh_d   = in_a;
            cnt_d  = shamt;
            shty_d = (in_op == OP_SLL) ? SH_SLL : (in_op == OP_SRL) ? SH_SRL : SH_SRA;
          end
        end
        default: begin
          res_d = '0;
          ill_d = 1'b1;
        end
      endcase
    end else if (state_q == S_SHIFT) begin
      sh_d  = sh_next;
      cnt_d = cnt_q - SHW'(1);
      if (cnt_q == SHW'(1)) res_d = sh_next;
    end
  end

  // Outputs decoded from state and held result
  always_comb begin
    in_ready    = (state_q == S_IDLE);
    out_valid   = (state_q == S_DONE);
    busy        = (state_q == S_SHIFT);
    out_result  = res_q;
    out_illegal = ill_q;
  end

endmodule
